// File: rtl/spi_resp_tx.sv
// SPI response transmitter: sends one 16-bit frame per 16 sclk, picking SPIN > CRED > BTN > IDLE at frame start.
// Optional odd-parity slot in bit 12 is enabled by defining SPI_RESP_TX_PARITY_EN.
module spi_resp_tx (
  input  logic        sclk,
  input  logic        reset,
  input  logic        cs,
  output logic        sdo,
  input  logic        spin_pend,
  input  logic [3:0]  reel1_idx,
  input  logic [3:0]  reel2_idx,
  input  logic [3:0]  reel3_idx,
  input  logic        cred_pend,
  input  logic [11:0] cred_val,
  input  logic        btn_pend,
  input  logic [3:0]  btn_mask,
  output logic        spin_ack_tgl,
  output logic        cred_ack_tgl,
  output logic        btn_ack_tgl,
  output logic        busy
);

  typedef enum logic [2:0] {
    TYP_IDLE = 3'b000,
    TYP_SPIN = 3'b001,
    TYP_CRED = 3'b010,
    TYP_BTN  = 3'b011
  } frame_type_e;

  frame_type_e sel_type;
  frame_type_e lat_type;
  logic [11:0] payload;
  logic        par_bit;
  logic [15:0] frame_now;
  logic [3:0]  bit_cnt;
  logic [3:0]  seq;
  logic [14:0] shreg;

  always_comb begin
    sel_type = TYP_IDLE;
    payload  = {8'h00, seq};
    if (spin_pend) begin
      sel_type = TYP_SPIN;
      payload  = {reel1_idx, reel2_idx, reel3_idx};
    end else if (cred_pend) begin
      sel_type = TYP_CRED;
      payload  = cred_val;
    end else if (btn_pend) begin
      sel_type = TYP_BTN;
      payload  = {8'h00, btn_mask};
    end
  end

`ifdef SPI_RESP_TX_PARITY_EN
  // Odd parity: the whole frame carries an odd number of ones.
  assign par_bit = ~(^{sel_type, payload});
`else
  assign par_bit = 1'b0;
`endif

  assign frame_now = {sel_type, par_bit, payload};

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      bit_cnt      <= 4'd0;
      shreg        <= 15'd0;
      lat_type     <= TYP_IDLE;
      seq          <= 4'd0;
      spin_ack_tgl <= 1'b0;
      cred_ack_tgl <= 1'b0;
      btn_ack_tgl  <= 1'b0;
    end else if (cs) begin
      // Deselect aborts the frame; the same source is picked again at the next start.
      bit_cnt <= 4'd0;
      shreg   <= 15'd0;
    end else begin
      bit_cnt <= bit_cnt + 4'd1;
      if (bit_cnt == 4'd0) begin
        shreg    <= frame_now[14:0];
        lat_type <= sel_type;
      end else begin
        shreg <= {shreg[13:0], 1'b0};
      end
      if (bit_cnt == 4'd15) begin
        seq <= seq + 4'd1;
        case (lat_type)
          TYP_SPIN: spin_ack_tgl <= ~spin_ack_tgl;
          TYP_CRED: cred_ack_tgl <= ~cred_ack_tgl;
          TYP_BTN:  btn_ack_tgl  <= ~btn_ack_tgl;
          default:  ;
        endcase
      end
    end
  end

  // Bit 15 goes out straight from the live inputs so the MCU sees it before the first edge.
  assign sdo  = reset & ~cs & ((bit_cnt == 4'd0) ? frame_now[15] : shreg[14]);
  assign busy = (bit_cnt != 4'd0);

endmodule
